pos_cell_reader: RTL and testbench

- Read-side sequencer for one per-cell position RAM (single-port altera_syncram wrapper).
- Address 0 holds the particle count; addresses 1..count hold {posz, posy, posx}.
- On start, reads the count, then streams every particle word to the downstream force pipeline over a valid/ready interface.
- Absorbs the RAM's 2-cycle read latency and downstream backpressure with a small credit-managed FIFO.

---
 rtl/pos_reader_pkg.sv | 20 ++
 rtl/pos_reader_fifo.sv | 64 ++++++
 rtl/pos_cell_reader.sv | 205 ++++++++++++++++++++
 tb/tb_pos_cell_reader.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pos_reader_pkg.sv
// Shared state encoding and constants for the per-cell position reader.
// Optional feature macro used by the reader: POS_READER_PARTICLE_ID_EN.
package pos_reader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_CNT,
        WAIT_CNT,
        STREAM,
        DRAIN,
        FINISH
    } state_t;

    localparam int RAM_RD_LATENCY = 2;

    // The particle count lives in the low ADDR_WIDTH bits of word 0.
    localparam int COUNT_ADDR = 0;
    localparam int COUNT_LSB  = 0;

endpackage

// File: rtl/pos_reader_fifo.sv
// First-word-fall-through FIFO: the head entry is visible on pop_data
// whenever empty is low. Push and pop in the same cycle are both honoured.
module pos_reader_fifo #(
    parameter int WIDTH     = 97,
    parameter int DEPTH     = 4,
    parameter int OCC_WIDTH = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [WIDTH-1:0]     push_data,
    input  logic                 pop,
    output logic [WIDTH-1:0]     pop_data,
    output logic                 empty,
    output logic [OCC_WIDTH-1:0] occupancy
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0]     mem_reg [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_reg;
    logic [PTR_W-1:0]     rd_ptr_reg;
    logic [OCC_WIDTH-1:0] occ_reg;
    logic                 do_push;
    logic                 do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty     = (occ_reg == '0);
    assign occupancy = occ_reg;
    assign pop_data  = mem_reg[rd_ptr_reg];
    assign do_pop    = pop && !empty;
    assign do_push   = push && ((occ_reg != OCC_WIDTH'(DEPTH)) || do_pop);

    // Storage carries no reset so it can map onto distributed/block RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            occ_reg    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (do_pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            case ({do_push, do_pop})
                2'b10:   occ_reg <= occ_reg + OCC_WIDTH'(1);
                2'b01:   occ_reg <= occ_reg - OCC_WIDTH'(1);
                default: occ_reg <= occ_reg;
            endcase
        end
    end

endmodule

// File: rtl/pos_cell_reader.sv
// Streams the particle words of one cell RAM (count at address 0) to a valid/ready sink.
// Optional macro POS_READER_PARTICLE_ID_EN adds out_pid = {cell_id, RAM address}.
module pos_cell_reader
    import pos_reader_pkg::*;
#(
    parameter int DATA_WIDTH    = 96,
    parameter int ADDR_WIDTH    = 8,
    parameter int PARTICLE_NUM  = 220,
    parameter int FIFO_DEPTH    = 4,
    parameter int CELL_ID_WIDTH = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [CELL_ID_WIDTH-1:0] cell_id,
    output logic [ADDR_WIDTH-1:0]    mem_address,
    output logic                     mem_rden,
    output logic                     mem_wren,
    input  logic [DATA_WIDTH-1:0]    mem_q,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic                     out_last,
    output logic                     busy,
    output logic                     done,
    output logic                     count_err
`ifdef POS_READER_PARTICLE_ID_EN
    ,
    output logic [CELL_ID_WIDTH+ADDR_WIDTH-1:0] out_pid
`endif
);

    localparam int LAT    = RAM_RD_LATENCY;
    localparam int OCC_W  = $clog2(FIFO_DEPTH + 1);
    localparam int SUM_W  = OCC_W + 1;
    localparam int WAIT_W = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [ADDR_WIDTH-1:0] COUNT_MAX = ADDR_WIDTH'(PARTICLE_NUM - 1);
`ifdef POS_READER_PARTICLE_ID_EN
    localparam int PID_W       = CELL_ID_WIDTH + ADDR_WIDTH;
    localparam int ENTRY_WIDTH = DATA_WIDTH + 1 + PID_W;
`else
    localparam int ENTRY_WIDTH = DATA_WIDTH + 1;
`endif

    state_t                  state_reg, state_next;
    logic [WAIT_W-1:0]       wait_cnt_reg;
    logic [ADDR_WIDTH-1:0]   count_reg;
    logic [ADDR_WIDTH-1:0]   rd_ptr_reg;
    logic                    count_err_reg;
    logic [LAT-1:0]          tag_valid_reg;
    logic [LAT-1:0]          tag_last_reg;
    logic [ADDR_WIDTH-1:0]   count_raw;
    logic [ADDR_WIDTH-1:0]   count_eff;
    logic                    count_over;
    logic                    issue;
    logic                    issue_last;
    logic [SUM_W-1:0]        inflight;
    logic                    credit_ok;
    logic                    fifo_push;
    logic                    fifo_pop;
    logic                    fifo_empty;
    logic [OCC_W-1:0]        fifo_occ;
    logic [ENTRY_WIDTH-1:0]  fifo_data;
    logic [ENTRY_WIDTH-1:0]  push_entry;
    logic [ENTRY_WIDTH-1:0]  head;
    logic                    last_xfer;

`ifdef POS_READER_PARTICLE_ID_EN
    logic [CELL_ID_WIDTH-1:0]         cell_id_reg;
    logic [LAT-1:0][ADDR_WIDTH-1:0]   tag_addr_reg;
    assign push_entry = {cell_id_reg, tag_addr_reg[LAT-1], tag_last_reg[LAT-1], mem_q};
    assign out_pid    = out_valid ? head[ENTRY_WIDTH-1 -: PID_W] : '0;
`else
    logic unused_cell_id;
    assign unused_cell_id = ^cell_id;
    assign push_entry     = {tag_last_reg[LAT-1], mem_q};
`endif

    assign count_raw  = mem_q[COUNT_LSB +: ADDR_WIDTH];
    assign count_over = (count_raw > COUNT_MAX);
    assign count_eff  = count_over ? COUNT_MAX : count_raw;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < LAT; i++) begin
            inflight = inflight + SUM_W'(tag_valid_reg[i]);
        end
    end

    // Every in-flight read owns a FIFO slot, so backpressure can never overflow it.
    assign credit_ok = (SUM_W'(fifo_occ) + inflight) < SUM_W'(FIFO_DEPTH);

    // An empty FIFO lets returning RAM data bypass straight to the output.
    assign head      = fifo_empty ? push_entry : fifo_data;
    assign out_valid = !fifo_empty || tag_valid_reg[LAT-1];
    assign out_data  = out_valid ? head[DATA_WIDTH-1:0] : '0;
    assign out_last  = out_valid && head[DATA_WIDTH];
    assign fifo_pop  = !fifo_empty && out_ready;
    assign fifo_push = tag_valid_reg[LAT-1] && !(fifo_empty && out_ready);
    assign last_xfer = out_valid && out_ready && out_last;

    assign issue_last = issue && (rd_ptr_reg == count_reg);
    assign mem_wren   = 1'b0;
    assign busy       = (state_reg != IDLE) && (state_reg != FINISH);
    assign done       = (state_reg == FINISH);
    assign count_err  = count_err_reg;

    always_comb begin
        state_next  = state_reg;
        mem_rden    = 1'b0;
        mem_address = '0;
        issue       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) state_next = RD_CNT;
            end
            RD_CNT: begin
                mem_rden    = 1'b1;
                mem_address = ADDR_WIDTH'(COUNT_ADDR);
                state_next  = WAIT_CNT;
            end
            WAIT_CNT: begin
                if (wait_cnt_reg == WAIT_W'(LAT - 1)) begin
                    state_next = (count_eff == '0) ? FINISH : STREAM;
                end
            end
            STREAM: begin
                if (credit_ok) begin
                    issue       = 1'b1;
                    mem_rden    = 1'b1;
                    mem_address = rd_ptr_reg;
                    if (rd_ptr_reg == count_reg) state_next = DRAIN;
                end
            end
            DRAIN: begin
                // Beats leave in order, so the last one leaving means nothing is left anywhere.
                if (last_xfer) state_next = FINISH;
            end
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            wait_cnt_reg  <= '0;
            count_reg     <= '0;
            rd_ptr_reg    <= '0;
            count_err_reg <= 1'b0;
            tag_valid_reg <= '0;
            tag_last_reg  <= '0;
`ifdef POS_READER_PARTICLE_ID_EN
            cell_id_reg   <= '0;
            tag_addr_reg  <= '0;
`endif
        end else begin
            state_reg     <= state_next;
            tag_valid_reg <= {tag_valid_reg[LAT-2:0], issue};
            tag_last_reg  <= {tag_last_reg[LAT-2:0], issue_last};
`ifdef POS_READER_PARTICLE_ID_EN
            tag_addr_reg  <= {tag_addr_reg[LAT-2:0], rd_ptr_reg};
`endif
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        count_err_reg <= 1'b0;
`ifdef POS_READER_PARTICLE_ID_EN
                        cell_id_reg   <= cell_id;
`endif
                    end
                end
                RD_CNT: wait_cnt_reg <= '0;
                WAIT_CNT: begin
                    wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
                    if (wait_cnt_reg == WAIT_W'(LAT - 1)) begin
                        count_reg  <= count_eff;
                        rd_ptr_reg <= ADDR_WIDTH'(1);
                        if (count_over) count_err_reg <= 1'b1;
                    end
                end
                STREAM: begin
                    if (issue) rd_ptr_reg <= rd_ptr_reg + ADDR_WIDTH'(1);
                end
                default: ;
            endcase
        end
    end

    pos_reader_fifo #(
        .WIDTH     (ENTRY_WIDTH),
        .DEPTH     (FIFO_DEPTH),
        .OCC_WIDTH (OCC_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .empty     (fifo_empty),
        .occupancy (fifo_occ)
    );

endmodule

// File: tb/tb_pos_cell_reader.sv
// Self-checking bench for pos_cell_reader: RAM model, table of cells, scoreboard of expected beats.
module tb_pos_cell_reader;

    localparam int DW = 96;
    localparam int AW = 8;
    localparam int PN = 220;
    localparam int FD = 4;
    localparam int CW = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [CW-1:0] cell_id;
    logic [AW-1:0] mem_address;
    logic          mem_rden;
    logic          mem_wren;
    logic [DW-1:0] mem_q;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          busy;
    logic          done;
    logic          count_err;
`ifdef POS_READER_PARTICLE_ID_EN
    logic [CW+AW-1:0] out_pid;
`endif

    always #5 clk = ~clk;

    pos_cell_reader #(
        .DATA_WIDTH    (DW),
        .ADDR_WIDTH    (AW),
        .PARTICLE_NUM  (PN),
        .FIFO_DEPTH    (FD),
        .CELL_ID_WIDTH (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .cell_id     (cell_id),
        .mem_address (mem_address),
        .mem_rden    (mem_rden),
        .mem_wren    (mem_wren),
        .mem_q       (mem_q),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .busy        (busy),
        .done        (done),
        .count_err   (count_err)
`ifdef POS_READER_PARTICLE_ID_EN
        ,
        .out_pid     (out_pid)
`endif
    );

    // Two-stage registered RAM: data for a read in cycle N is on mem_q in cycle N+2.
    logic [DW-1:0] ram [0:255];
    logic [DW-1:0] q1 = '0;
    logic [DW-1:0] q2 = '0;
    always @(posedge clk) begin
        if (mem_rden) q1 <= ram[mem_address];
        q2 <= q1;
    end
    assign mem_q = q2;

    typedef struct {
        logic [DW-1:0]    data;
        logic             last;
        logic [CW+AW-1:0] pid;
    } beat_t;

    typedef struct {
        int            stored;
        int            mode;
        logic [CW-1:0] cid;
        int            beats;
        bit            err;
    } vec_t;

    beat_t sb[$];
    vec_t  tbl[7];

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int rmode = 0;
    int first_valid, last_xfer, done_cyc, beats, rden_cnt, done_cnt;
    bit wren_seen = 0;
    bit prev_err = 0;
    bit prev_stall = 0;
    logic [DW-1:0] prev_data;
    logic          prev_last;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic ready_val(input int c);
        logic [3:0] pat;
        pat = 4'b1001;
        case (rmode)
            0:       return 1'b1;
            1:       return pat[c % 4];
            default: return ($urandom_range(0, 2) != 0);
        endcase
    endfunction

    // Sampled at the falling edge, away from the active edge.
    task automatic monitor();
        beat_t e;
        if (rst) begin
            prev_stall = 0;
            return;
        end
        if (prev_stall) begin
            check("stall_valid_hold", out_valid, 1'b1);
            check("stall_data_hold", {out_last, out_data}, {prev_last, prev_data});
        end
        if (mem_wren) wren_seen = 1;
        if (mem_rden) rden_cnt++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (out_valid && first_valid < 0) first_valid = cyc;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_beat: got %0h, expected no beat (cycle %0d)", out_data, cyc);
            end else begin
                e = sb.pop_front();
                check("beat_last_data", {out_last, out_data}, {e.last, e.data});
`ifdef POS_READER_PARTICLE_ID_EN
                check("beat_pid", out_pid, e.pid);
`endif
            end
            beats++;
            last_xfer = cyc;
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_last  = out_last;
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        cyc++;
        out_ready = ready_val(cyc);
    endtask

    task automatic load_cell(input int stored, input int n, input logic [CW-1:0] cid);
        beat_t e;
        ram[0] = {64'hdead_beef_0123_4567, 24'h5a5a5a, 8'(stored)};
        for (int i = 1; i <= n; i++) begin
            ram[i] = {$urandom, $urandom, $urandom};
            e.data = ram[i];
            e.last = (i == n);
            e.pid  = {cid, 8'(i)};
            sb.push_back(e);
        end
        first_valid = -1;
        last_xfer   = -1;
        done_cyc    = -1;
        beats       = 0;
        rden_cnt    = 0;
        done_cnt    = 0;
    endtask

    task automatic run_cell(input int stored, input int mode, input logic [CW-1:0] cid,
                            input int exp_n, input bit exp_err);
        int s;
        rmode = mode;
        load_cell(stored, exp_n, cid);
        check("busy_before_start", busy, 1'b0);
        check("count_err_sticky", count_err, prev_err);
        start   = 1'b1;
        cell_id = cid;
        s = cyc;
        tick();
        start   = 1'b0;
        cell_id = CW'($urandom);
        check("busy_after_start", busy, 1'b1);
        check("count_err_cleared", count_err, 1'b0);
        for (int k = 0; k < 3000 && done_cyc < 0; k++) tick();
        if (done_cyc < 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL done_timeout: got no done, expected done within 3000 cycles (count %0d)", stored);
        end
        check("busy_after_done", busy, 1'b0);
        check("count_err", count_err, exp_err);
        check("beat_count", beats, exp_n);
        check("scoreboard_empty", sb.size(), 0);
        check("rden_count", rden_cnt, exp_n + 1);
        if (exp_n > 0) begin
            check("first_beat_latency", first_valid - s, 6);
            check("done_after_last", done_cyc, last_xfer + 1);
        end else begin
            check("no_out_valid", first_valid, -1);
            check("done_latency", done_cyc - s, 4);
        end
        tick();
        tick();
        check("single_done_pulse", done_cnt, 1);
        $display("cell %03h stored %0d mode %0d: %0d beats, done at +%0d, count_err %0d",
                 cid, stored, mode, beats, done_cyc - s, count_err);
        sb.delete();
        prev_err = exp_err;
    endtask

    initial begin
        tbl[0] = '{stored: 5,   mode: 0, cid: 12'h101, beats: 5,   err: 1'b0};
        tbl[1] = '{stored: 0,   mode: 0, cid: 12'h102, beats: 0,   err: 1'b0};
        tbl[2] = '{stored: 8,   mode: 1, cid: 12'h103, beats: 8,   err: 1'b0};
        tbl[3] = '{stored: 250, mode: 0, cid: 12'h104, beats: 219, err: 1'b1};
        tbl[4] = '{stored: 3,   mode: 2, cid: 12'h543, beats: 3,   err: 1'b0};
        tbl[5] = '{stored: 219, mode: 2, cid: 12'h105, beats: 219, err: 1'b0};
        tbl[6] = '{stored: 1,   mode: 0, cid: 12'h106, beats: 1,   err: 1'b0};

        for (int i = 0; i < 256; i++) ram[i] = '0;
        rst       = 1'b1;
        start     = 1'b0;
        cell_id   = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_outputs", {out_valid, out_last, busy, done, count_err, mem_rden},  6'b0);
        check("rst_out_data", out_data, '0);
        check("rst_mem_address", mem_address, '0);
`ifdef POS_READER_PARTICLE_ID_EN
        check("rst_out_pid", out_pid, '0);
`endif
        rst = 1'b0;
        tick();

        for (int v = 0; v < 7; v++) begin
            run_cell(tbl[v].stored, tbl[v].mode, tbl[v].cid, tbl[v].beats, tbl[v].err);
        end

        // Reset two beats into a ten-particle cell, then stream a fresh cell.
        rmode = 0;
        load_cell(10, 10, 12'h2aa);
        start   = 1'b1;
        cell_id = 12'h2aa;
        tick();
        start = 1'b0;
        for (int k = 0; k < 60 && beats < 2; k++) tick();
        check("pre_reset_beats", beats, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_outputs", {out_valid, out_last, busy, done, count_err, mem_rden}, 6'b0);
        check("midrst_out_data", out_data, '0);
        sb.delete();
        done_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            check("post_rst_quiet", {out_valid, done, busy, mem_rden}, 4'b0);
        end
        check("post_rst_no_done", done_cnt, 0);
        prev_err = 0;
        run_cell(4, 2, 12'h3c3, 4, 1'b0);

        check("mem_wren_low", wren_seen, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
